// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion definitions: round count, Rcon table, FSM states
// and the round-key word type.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  // Indexed directly by the 4-bit round counter; only entries 1..10 are used.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [127:0] round_key_t;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a combinational ROM; shared by key expansion and the
// round stages.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  // Entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub = SBOX_ROM[{~data, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// bank that the round stages read combinationally by index.
module aes_key_schedule #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         ready
);
  import aes_pkg::*;

  state_t     state, state_next;
  logic [3:0] round_cnt;
  round_key_t bank [0:10];
  round_key_t prev_rk, rk_next;
  logic       accept, step, last;

  logic [31:0] wa, wb, wc, wd, rot, subw, t, we, wf, wg, wh;

  always_comb begin
    prev_rk = '0;
    for (int i = 0; i < 10; i++)
      if (round_cnt == 4'(i + 1)) prev_rk = bank[i];
  end

  assign {wa, wb, wc, wd} = prev_rk;
  assign rot = {wd[23:0], wd[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (.data(rot[8*g +: 8]), .sub(subw[8*g +: 8]));
  end

  // One full round per cycle: S-box layer followed by the serial XOR chain.
  assign t  = subw ^ {RCON[round_cnt], 24'h0};
  assign we = wa ^ t;
  assign wf = wb ^ we;
  assign wg = wc ^ wf;
  assign wh = wd ^ wg;
  assign rk_next = {we, wf, wg, wh};

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (round_cnt == 4'(NUM_ROUNDS)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      round_cnt <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      for (int i = 0; i <= 10; i++) bank[i] <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        bank[0]   <= key;
        round_cnt <= 4'd1;
        busy      <= 1'b1;
        ready     <= 1'b0;
      end
      if (step) begin
        for (int i = 1; i <= 10; i++)
          if (round_cnt == 4'(i)) bank[i] <= rk_next;
        round_cnt <= round_cnt + 4'd1;
      end
      if (last) begin
        busy  <= 1'b0;
        ready <= 1'b1;
      end
    end
  end

  always_comb begin
    rk_data = '0;
    for (int i = 0; i <= 10; i++)
      if (rk_idx == 4'(i)) rk_data = bank[i];
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench: FIPS-197 word-array key expansion with a field-arithmetic
// S-box as reference, checked every cycle, plus literal round-key vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         busy, ready;

  int errors = 0;
  int checks = 0;

  aes_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .rk_idx(rk_idx), .rk_data(rk_data), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] p = 8'h00;
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  typedef logic [127:0] sched_t [0:10];

  function automatic sched_t expand_ref(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_ref(temp[31:24]), sbox_ref(temp[23:16]),
                sbox_ref(temp[15:8]), sbox_ref(temp[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int j = 0; j <= 10; j++) s[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return s;
  endfunction

  // ---------------- cycle-level expectation ----------------
  logic [127:0] m_bank [0:10];
  sched_t       m_sched;
  bit           m_busy = 1'b0, m_ready = 1'b0, chk_en = 1'b0;
  int           m_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 1'b0; m_ready = 1'b0; m_cnt = 0; chk_en = 1'b1;
      for (int i = 0; i <= 10; i++) m_bank[i] = '0;
    end else if (m_busy) begin
      m_cnt++;
      m_bank[m_cnt] = m_sched[m_cnt];
      if (m_cnt == 10) begin m_busy = 1'b0; m_ready = 1'b1; end
    end else if (start) begin
      m_sched   = expand_ref(key);
      m_bank[0] = key;
      m_cnt = 0; m_busy = 1'b1; m_ready = 1'b0;
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 128'(busy), 128'(m_busy));
      check("ready", 128'(ready), 128'(m_ready));
      check("busy_and_ready", 128'(busy & ready), 128'(0));
      check("rk_data", rk_data, (rk_idx <= 4'd10) ? m_bank[rk_idx] : 128'h0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic [127:0] k);
    @(posedge clk); #1;
    start = 1'b1; key = k;
    @(posedge clk); #1;
    start = 1'b0; key = ~k;
  endtask

  // Counts edges after the accepting edge until ready; optional stray starts.
  task automatic wait_ready(input string name, input bit strays);
    int n = 0;
    while (!ready && n <= 30) begin
      start = strays && (n == 3 || n == 7);
      key   = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check(name, 128'(n), 128'd10);
  endtask

  task automatic read_at(input string name, input logic [3:0] idx, input logic [127:0] exp);
    rk_idx = idx;
    #1;
    check(name, rk_data, exp);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; key = '0; rk_idx = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_ready", 128'(ready), 128'(0));
    read_at("reset_rk0", 4'd0, 128'h0);
    rst = 1'b1;

    // FIPS-197 A.1 key
    pulse_start(KEY_A1);
    check("a1_busy_after_accept", 128'(busy), 128'(1));
    wait_ready("a1_latency", 1'b0);
    read_at("a1_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_at("a1_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_at("a1_rk0", 4'd0, KEY_A1);
    for (int i = 11; i < 16; i++) read_at("done_oob", 4'(i), 128'h0);
    repeat (3) @(posedge clk);
    #1;
    read_at("a1_rk10_stable", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Re-expand from DONE with the all-zero key; strays at cycles 3 and 7.
    pulse_start(KEY_ZERO);
    check("redo_ready_drop", 128'(ready), 128'(0));
    rk_idx = 4'd13;
    wait_ready("zero_latency", 1'b1);
    read_at("zero_rk1", 4'd1, 128'h62636363626363636263636362636363);
    read_at("zero_rk10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Reset in the middle of an expansion.
    pulse_start(KEY_A1);
    rk_idx = 4'd12;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_ready", 128'(ready), 128'(0));
    for (int i = 0; i < 16; i++) read_at("midrst_rk", 4'(i), 128'h0);
    rst = 1'b1;

    // Fresh start after reset completes normally.
    pulse_start(KEY_C1);
    wait_ready("c1_latency", 1'b0);
    read_at("c1_rk10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // start coincident with reset: reset wins.
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; key = KEY_A1;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    check("rst_vs_start_busy", 128'(busy), 128'(0));
    read_at("rst_vs_start_rk0", 4'd0, 128'h0);
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
